// File: rtl/od_pkg.sv
// Shared types, default timing and helpers for the ultrasonic ranging path.
// Used by the trigger generator and the echo-measuring block.
package od_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    WAIT_FALL = 3'd3,
    HOLDOFF   = 3'd4
  } od_trig_state_t;

  // Default timing shared by both sides of the echo interface
  localparam int unsigned OD_CLK_FREQ_HZ     = 50_000_000;
  localparam int unsigned OD_TRIG_US         = 10;
  localparam int unsigned OD_ECHO_TIMEOUT_US = 25_000;
  localparam int unsigned OD_PERIOD_US       = 60_000;

  // Microseconds to clock cycles; freq is a whole multiple of 1 MHz
  function automatic int unsigned us2cyc(input int unsigned freq, input int unsigned us);
    longint unsigned cyc;
    cyc = (64'(freq) / 64'd1_000_000) * 64'(us);
    return cyc[31:0];
  endfunction

endpackage

// File: rtl/od_trigger_gen_if.sv
// Control/status bundle between the ranging sequencer and its user.
// master: the side that requests measurements and drives the raw echo.
// slave:  the trigger generator itself.
interface od_trigger_gen_if;
  logic enable;
  logic start;
  logic echo_pulse;
  logic trig_out;
  logic busy;
  logic echo_done;
  logic time_out;

  modport master (
    output enable, start, echo_pulse,
    input  trig_out, busy, echo_done, time_out
  );

  modport slave (
    input  enable, start, echo_pulse,
    output trig_out, busy, echo_done, time_out
  );
endinterface

// File: rtl/od_sync2.sv
// Generic 2-flop synchronizer, async active-low reset.
module od_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/od_trigger_gen.sv
// Ultrasonic trigger generator / ranging-cycle sequencer.
// Issues the trigger pulse, watches the synchronized echo, flags timeout
// and enforces a minimum spacing between trigger rising edges.
// Optional macro OD_AUTO_RETRIG_EN: free-running mode, retriggers every
// PER_CYC cycles while enable is high (start is ignored).
module od_trigger_gen
  import od_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = OD_CLK_FREQ_HZ,
  parameter int unsigned TRIG_US         = OD_TRIG_US,
  parameter int unsigned ECHO_TIMEOUT_US = OD_ECHO_TIMEOUT_US,
  parameter int unsigned PERIOD_US       = OD_PERIOD_US
) (
  input  logic             clk,
  input  logic             rst,
  od_trigger_gen_if.slave  bus
);

  localparam int unsigned TRIG_CYC = us2cyc(CLK_FREQ_HZ, TRIG_US);
  localparam int unsigned TMO_CYC  = us2cyc(CLK_FREQ_HZ, ECHO_TIMEOUT_US);
  localparam int unsigned PER_CYC  = us2cyc(CLK_FREQ_HZ, PERIOD_US);
  localparam int          CW       = $clog2(PER_CYC + 1);

  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] PER_LAST  = CW'(PER_CYC - 1);
  localparam logic [CW-1:0] PER_SAT   = CW'(PER_CYC);

  generate
    if (CLK_FREQ_HZ % 1_000_000 != 0) begin : g_bad_freq
      $error("od_trigger_gen: CLK_FREQ_HZ must be a multiple of 1 MHz");
    end
    if (PER_CYC <= TRIG_CYC + TMO_CYC) begin : g_bad_timing
      $error("od_trigger_gen: period must exceed trigger plus echo timeout");
    end
  endgenerate

  od_trig_state_t state_q, state_d;
  logic [CW-1:0]  phase_q, phase_d;
  logic [CW-1:0]  per_q,   per_d;
  logic           trig_q,  trig_d;
  logic           done_q,  done_d;
  logic           tmo_q,   tmo_d;
  logic           echo_s;
  logic           launch_idle;

  od_sync2 #(.WIDTH(1)) u_echo_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (bus.echo_pulse),
    .q_o   (echo_s)
  );

`ifdef OD_AUTO_RETRIG_EN
  assign launch_idle = bus.enable;
`else
  assign launch_idle = bus.start && bus.enable;
`endif

  // Next-state, counter and output-pulse decode for the ranging sequence
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    per_d   = (per_q == PER_SAT) ? per_q : per_q + 1'b1;
    trig_d  = 1'b0;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        if (launch_idle) begin
          state_d = TRIG;
          per_d   = '0;
          trig_d  = 1'b1;
        end
      end
      TRIG: begin
        trig_d = 1'b1;
        if (phase_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          phase_d = '0;
          trig_d  = 1'b0;
        end
      end
      WAIT_RISE: begin
        // A rise on the final window cycle could never complete, so the
        // timeout is decided first here.
        if (phase_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = HOLDOFF;
          phase_d = '0;
        end else if (echo_s) begin
          state_d = WAIT_FALL;
        end
      end
      WAIT_FALL: begin
        // Echo fall wins over a coincident timeout
        if (!echo_s) begin
          done_d  = 1'b1;
          state_d = HOLDOFF;
          phase_d = '0;
        end else if (phase_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = HOLDOFF;
          phase_d = '0;
        end
      end
      HOLDOFF: begin
        if (per_q == PER_LAST) begin
          phase_d = '0;
`ifdef OD_AUTO_RETRIG_EN
          if (bus.enable) begin
            state_d = TRIG;
            per_d   = '0;
            trig_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      per_q   <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      per_q   <= per_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.trig_out  = trig_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.echo_done = done_q;
  assign bus.time_out  = tmo_q;

endmodule

// File: tb/tb_od_trigger_gen.sv
// Testbench for od_trigger_gen: directed and randomized scenarios checked
// cycle by cycle against an event-timeline reference model.
module tb_od_trigger_gen;
  import od_pkg::*;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned T_US   = 10;
  localparam int unsigned TMO_US = 100;
  localparam int unsigned PER_US = 200;

  localparam int TRIG_C = int'(T_US   * (CLK_HZ / 1_000_000));
  localparam int TMO_C  = int'(TMO_US * (CLK_HZ / 1_000_000));
  localparam int PER_C  = int'(PER_US * (CLK_HZ / 1_000_000));

`ifdef OD_AUTO_RETRIG_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int NC   = 800;
  localparam int TAIL = 260;
  localparam int ACT  = NC - TAIL;

  logic clk;
  logic rst;
  od_trigger_gen_if bus();

  od_trigger_gen #(
    .CLK_FREQ_HZ     (CLK_HZ),
    .TRIG_US         (T_US),
    .ECHO_TIMEOUT_US (TMO_US),
    .PERIOD_US       (PER_US)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit         st_a [NC];
  bit         en_a [NC];
  bit         ec_a [NC];
  logic [3:0] exp_a[NC];   // {trig, busy, echo_done, time_out}
  int         rise_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NC; i++) begin
      st_a[i] = 1'b0;
      en_a[i] = 1'b0;
      ec_a[i] = 1'b0;
    end
  endtask

  // Echo as seen by the sequencer: raw input delayed two cycles
  function automatic bit es(input int j);
    if (j < 2 || j - 2 >= NC) return 1'b0;
    return ec_a[j-2];
  endfunction

  function automatic void mark(input int idx, input int b);
    if (idx >= 0 && idx < NC) exp_a[idx][b] = 1'b1;
  endfunction

  // Reference timeline: a launch decided in cycle c gives trigger in
  // c+1..c+TRIG, busy in c+1..c+PER, and an echo window of TMO cycles
  // starting right after the trigger falls.
  task automatic build_expected();
    int  k, c, w0, last, j, m;
    bit  launch, rose, fell;
    for (int i = 0; i < NC; i++) exp_a[i] = '0;
    k = 0;
    while (k < NC) begin
      launch = AUTO ? en_a[k] : (st_a[k] && en_a[k]);
      if (!launch) begin
        k++;
      end else begin
        c = k;
        for (int i = 1; i <= TRIG_C; i++) mark(c + i, 3);
        for (int i = 1; i <= PER_C; i++)  mark(c + i, 2);
        w0   = c + TRIG_C + 1;
        last = w0 + TMO_C - 1;
        j = w0;
        while (j < last && !es(j)) j++;
        rose = (j < last);
        fell = 1'b0;
        m    = 0;
        if (rose) begin
          m = j + 1;
          while (m <= last && es(m)) m++;
          fell = (m <= last);
        end
        if (fell) mark(m + 1, 1);
        else      mark(last + 1, 0);
        k = AUTO ? c + PER_C : c + PER_C + 1;
      end
    end
  endtask

  task automatic run_scenario(input string name);
    logic prev_trig;
    logic [3:0] obs;
    build_expected();
    rise_q.delete();
    prev_trig = 1'b0;
    for (int k = 0; k < NC; k++) begin
      @(posedge clk);
      #1;
      bus.start      = st_a[k];
      bus.enable     = en_a[k];
      bus.echo_pulse = ec_a[k];
      @(negedge clk);
      obs = {bus.trig_out, bus.busy, bus.echo_done, bus.time_out};
      check_val($sformatf("%s@%0d", name, k), {28'd0, obs}, {28'd0, exp_a[k]});
      if (bus.trig_out && !prev_trig) rise_q.push_back(k);
      prev_trig = bus.trig_out;
    end
    bus.start = 1'b0;
    bus.enable = 1'b0;
    bus.echo_pulse = 1'b0;
  endtask

  task automatic set_echo(input int from, input int upto);
    for (int i = from; i <= upto && i < ACT; i++) ec_a[i] = 1'b1;
  endtask

  task automatic set_en(input int from, input int upto);
    for (int i = from; i <= upto && i < ACT; i++) en_a[i] = 1'b1;
  endtask

  initial begin
    int p, len;
    rst = 1'b0;
    bus.enable = 1'b0;
    bus.start = 1'b0;
    bus.echo_pulse = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("reset_trig", {31'd0, bus.trig_out},  32'd0);
    check_val("reset_busy", {31'd0, bus.busy},      32'd0);
    check_val("reset_done", {31'd0, bus.echo_done}, 32'd0);
    check_val("reset_tmo",  {31'd0, bus.time_out},  32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset in the middle of the trigger pulse
    @(posedge clk); #1;
    bus.enable = 1'b1;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check_val("rstmid_pre_trig", {31'd0, bus.trig_out}, 32'd1);
    check_val("rstmid_pre_busy", {31'd0, bus.busy},     32'd1);
    rst = 1'b0;
    #1;
    check_val("rstmid_trig", {31'd0, bus.trig_out}, 32'd0);
    check_val("rstmid_busy", {31'd0, bus.busy},     32'd0);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rstmid_hold_trig", {31'd0, bus.trig_out}, 32'd0);
    check_val("rstmid_hold_busy", {31'd0, bus.busy},     32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Normal echo (also the full trigger after the reset above)
    clear_stim();
    st_a[0] = 1'b1;
    set_en(0, 299);
    set_echo(20, 49);
    run_scenario("normal");

    // No echo
    clear_stim();
    st_a[0] = 1'b1;
    set_en(0, 299);
    run_scenario("noecho");

    // Stuck echo, extra starts during hold-off, then a start with echo already high
    clear_stim();
    st_a[0] = 1'b1; st_a[150] = 1'b1; st_a[200] = 1'b1; st_a[230] = 1'b1;
    set_en(0, 499);
    set_echo(15, 519);
    run_scenario("stuck");
    if (!AUTO) check_val("stuck_second_rise", rise_q.size() > 1 ? rise_q[1] : -1, 231);

    // Gating: start without enable, enable dropped while echo is high
    clear_stim();
    st_a[0] = 1'b1;
    st_a[5] = 1'b1;
    set_en(5, 39);
    set_echo(30, 59);
    st_a[300] = 1'b1;
    run_scenario("gating");

    // Enable held high then dropped mid-cycle
    clear_stim();
    st_a[0] = 1'b1;
    set_en(0, 449);
    set_echo(40, 70);
    run_scenario("autorun");
`ifdef OD_AUTO_RETRIG_EN
    check_val("auto_rises", rise_q.size(), 3);
    for (int i = 1; i < rise_q.size(); i++)
      check_val($sformatf("auto_period%0d", i), rise_q[i] - rise_q[i-1], PER_C);
`else
    check_val("single_rises", rise_q.size(), 1);
`endif

    // Randomized traffic
    for (int r = 0; r < 5; r++) begin
      clear_stim();
      for (int i = 0; i < ACT; i++) begin
        en_a[i] = ($urandom_range(0, 9) != 0);
        st_a[i] = ($urandom_range(0, 39) == 0);
      end
      for (int e = 0; e < 4; e++) begin
        p   = int'($urandom_range(0, 480));
        len = int'($urandom_range(1, 150));
        set_echo(p, p + len - 1);
      end
      run_scenario($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
